// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state type.
`timescale 1ns/1ps
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising edge where both are high; valid never depends on ready.
`timescale 1ns/1ps
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/rca.sv
// 4-bit ripple-carry adder used as the per-cycle datapath slice.
`timescale 1ns/1ps
module rca
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one 4-bit slice per cycle, LSB nibble first,
// carrying between slices in a register; result returned over a valid/ready handshake.
`timescale 1ns/1ps
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus,
  output state_t                dbg_state
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic [W-1:0]    sum_shift;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NIBBLE_W-1:0] slice_s;
  logic            slice_co;

  rca u_rca (
    .a  (a_sh_q[NIBBLE_W-1:0]),
    .b  (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Each new slice enters at the top so the LSB nibble ends up at the bottom after NIBBLES shifts.
  generate
    if (NIBBLES == 1) begin : g_single
      assign sum_shift = slice_s;
    end else begin : g_multi
      assign sum_shift = {slice_s, sum_sh_q[W-1:NIBBLE_W]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_shift;
        carry_d  = slice_co;
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_sh_q;
  assign bus.c_out     = carry_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and streaming checks of nibble_serial_adder against an arithmetic reference model.
`timescale 1ns/1ps
module tb_nibble_serial_adder;
  import adder_pkg::*;

  localparam int N4 = 4;
  localparam int W4 = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) if1 ();
  state_t st4, st1;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4), .dbg_state(st4));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .dbg_state(st1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // out_ready source for the 4-nibble DUT: directed level or per-cycle random
  logic ready_dir = 1'b1;
  logic rand_mode = 1'b0;
  logic rnd_bit   = 1'b1;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign if4.out_ready = rand_mode ? rnd_bit : ready_dir;

  // scoreboard: expected {c_out,sum} per accepted operation
  logic [W4:0]   exp_q[$];
  int unsigned   cyc = 0;
  int unsigned   acc_edge = 0;
  int            hs_cnt = 0;
  logic [W4-1:0] last_sum = '0;
  logic          last_cout = 1'b0;
  logic          prev_hold = 1'b0;
  logic          prev_ov = 1'b0;
  logic [W4-1:0] prev_sum = '0;
  logic          prev_cout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      check("busy_vs_in_ready", 64'(if4.busy), 64'(!if4.in_ready));
      if (prev_hold) begin
        check("hold_valid", 64'(if4.out_valid), 64'(1));
        check("hold_in_ready", 64'(if4.in_ready), 64'(0));
        check("hold_sum", 64'(if4.sum), 64'(prev_sum));
        check("hold_cout", 64'(if4.c_out), 64'(prev_cout));
      end
      if (if4.out_valid && !prev_ov)
        check("latency", 64'(cyc - acc_edge + 1), 64'(N4 + 1));
      if (if4.in_valid && if4.in_ready) begin
        exp_q.push_back({1'b0, if4.a} + {1'b0, if4.b} + {{W4{1'b0}}, if4.c_in});
        acc_edge = cyc + 1;
      end
      if (if4.out_valid && if4.out_ready) begin
        check("pending_ops", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          logic [W4:0] e;
          e = exp_q.pop_front();
          check("sum", 64'(if4.sum), 64'(e[W4-1:0]));
          check("c_out", 64'(if4.c_out), 64'(e[W4]));
        end
        last_sum  = if4.sum;
        last_cout = if4.c_out;
        hs_cnt++;
      end
      prev_hold = if4.out_valid && !if4.out_ready;
      prev_ov   = if4.out_valid;
      prev_sum  = if4.sum;
      prev_cout = if4.c_out;
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic ci);
    int n;
    n = 0;
    while (!if4.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 64'(if4.in_ready), 64'(1));
    if4.a = a; if4.b = b; if4.c_in = ci; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a = W4'($urandom); if4.b = W4'($urandom); if4.c_in = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_hs4(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("handshake_timeout", 64'(hs_cnt), 64'(target));
  endtask

  task automatic edges_to_valid4(output int n);
    n = 1;
    while (!if4.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int t;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.c_in = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0; if1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(if4.in_ready), 64'(1));
    check("rst_out_valid", 64'(if4.out_valid), 64'(0));
    check("rst_busy", 64'(if4.busy), 64'(0));
    check("rst_sum", 64'(if4.sum), 64'(0));
    check("rst_cout", 64'(if4.c_out), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // basic add, latency pinned by hand
    t = hs_cnt;
    send4(16'h1234, 16'h4321, 1'b0);
    edges_to_valid4(n);
    check("t1_latency", 64'(n), 64'(5));
    wait_hs4(t + 1);
    check("t1_sum", 64'(last_sum), 64'(16'h5555));
    check("t1_cout", 64'(last_cout), 64'(0));

    // carry ripples through every nibble
    send4(16'hFFFF, 16'h0001, 1'b0);
    wait_hs4(t + 2);
    check("t2_sum", 64'(last_sum), 64'(16'h0000));
    check("t2_cout", 64'(last_cout), 64'(1));

    send4(16'hFFFF, 16'hFFFF, 1'b1);
    wait_hs4(t + 3);
    check("t3_sum", 64'(last_sum), 64'(16'hFFFF));
    check("t3_cout", 64'(last_cout), 64'(1));

    // backpressure in DONE while new operands are offered
    ready_dir = 1'b0;
    send4(16'hABCD, 16'h1111, 1'b1);
    edges_to_valid4(n);
    for (int i = 0; i < 3; i++) begin
      if4.in_valid = 1'b1; if4.a = W4'($urandom); if4.b = W4'($urandom);
      @(posedge clk); #1;
      check("bp_in_ready", 64'(if4.in_ready), 64'(0));
      check("bp_sum", 64'(if4.sum), 64'(16'hBCDF));
      check("bp_cout", 64'(if4.c_out), 64'(0));
    end
    if4.in_valid = 1'b0;
    ready_dir = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_next", 64'(if4.in_ready), 64'(1));
    check("bp_hs_count", 64'(hs_cnt), 64'(t + 4));
    check("bp_result", 64'(last_sum), 64'(16'hBCDF));
    send4(16'h0F0F, 16'h00F1, 1'b0);
    wait_hs4(t + 5);
    check("bp_next_sum", 64'(last_sum), 64'(16'h1000));
    check("bp_next_cout", 64'(last_cout), 64'(0));

    // reset during the second RUN cycle
    send4(16'h2222, 16'h3333, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_in_ready", 64'(if4.in_ready), 64'(1));
    check("mr_out_valid", 64'(if4.out_valid), 64'(0));
    check("mr_sum", 64'(if4.sum), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    check("mr_no_handshake", 64'(hs_cnt), 64'(t + 5));
    send4(16'h8000, 16'h8000, 1'b1);
    wait_hs4(t + 6);
    check("mr_next_sum", 64'(last_sum), 64'(16'h0001));
    check("mr_next_cout", 64'(last_cout), 64'(1));

    // single-nibble instance
    if1.a = 4'h9; if1.b = 4'h8; if1.c_in = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0; if1.a = 4'h0; if1.b = 4'h0; if1.c_in = 1'b0;
    n = 1;
    while (!if1.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("n1_latency", 64'(n), 64'(2));
    check("n1_sum", 64'(if1.sum), 64'(4'h2));
    check("n1_cout", 64'(if1.c_out), 64'(1));
    @(posedge clk); #1;
    check("n1_idle_after", 64'(if1.in_ready), 64'(1));

    // back-to-back stream with random out_ready
    rand_mode = 1'b1;
    t = hs_cnt;
    for (int i = 0; i < 1000; i++)
      send4(W4'($urandom), W4'($urandom), 1'($urandom_range(0, 1)));
    wait_hs4(t + 1000);
    rand_mode = 1'b0;
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
